// File: rtl/avalon_led_pio_pkg.sv
// Purpose : shared constants and write-decode helper for the LED PIO with blink engine.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: word addresses, CTRL bit indices, one-hot write strobe struct and its decoder.
package avalon_led_pio_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd1;
   localparam logic [2:0] ADDR_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_CTRL   = 3'd3;
   localparam logic [2:0] ADDR_SET    = 3'd4;
   localparam logic [2:0] ADDR_CLR    = 3'd5;
   localparam logic [2:0] ADDR_TGL    = 3'd6;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_PHASE = 1;

   // One strobe per writable register; at most one is set in any cycle.
   typedef struct packed {
      logic data;
      logic mask;
      logic period;
      logic ctrl;
      logic set;
      logic clr;
      logic tgl;
   } wr_dec_t;

   function automatic wr_dec_t decode_write(input logic [2:0] addr, input logic wr);
      wr_dec_t d;
      d = '0;
      if (wr) begin
         case (addr)
            ADDR_DATA:   d.data   = 1'b1;
            ADDR_MASK:   d.mask   = 1'b1;
            ADDR_PERIOD: d.period = 1'b1;
            ADDR_CTRL:   d.ctrl   = 1'b1;
            ADDR_SET:    d.set    = 1'b1;
            ADDR_CLR:    d.clr    = 1'b1;
            ADDR_TGL:    d.tgl    = 1'b1;
            default:     d        = '0;   // address 7 is reserved
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Purpose : half-period prescaler that toggles a blink phase bit every period+1 cycles.
// Latency : phase changes on the edge where cnt==period; restart/disable act on the same edge.
// Backpressure: none; free-running while enabled.
// Ports   : clk, reset_n (async, active-low); period = half-period minus 1;
//           en = run (low clears cnt and phase); restart = clear cnt only; phase = blink phase.
module led_blink_timer #(
   parameter int PERIOD_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic                    en,
   input  logic                    restart,
   output logic                    phase
);

   logic [PERIOD_WIDTH-1:0] cnt;

   // Priority: disable beats restart beats terminal count. A restart on the
   // terminal-count edge therefore suppresses that toggle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (restart) begin
         cnt   <= '0;
      end else if (cnt == period) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/avalon_led_pio_blink.sv
// Purpose : Avalon-MM LED output PIO with atomic set/clear/toggle and a hardware blink engine.
// Latency : zero-wait writes; combinational readdata; out_port follows register/phase changes 1 cycle later.
// Backpressure: none; the slave accepts every access without wait states.
// Ports   : clk, reset_n (async, active-low); address/chipselect/write_n/writedata = Avalon write;
//           readdata = zero-extended register read; out_port = registered LED drive.
module avalon_led_pio_blink
   import avalon_led_pio_pkg::*;
#(
   parameter int                     DATA_WIDTH   = 16,
   parameter int                     PERIOD_WIDTH = 24,
   parameter logic [DATA_WIDTH-1:0]  RESET_DATA   = '0,
   parameter int unsigned            RESET_PERIOD = 12499999
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic                    wr;
   wr_dec_t                 wdec;
   logic [DATA_WIDTH-1:0]   wd_data;

   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH-1:0]   mask;
   logic [PERIOD_WIDTH-1:0] period;
   logic                    en;
   logic                    phase;
   logic                    timer_en;

   // Upper writedata bits beyond each register width are deliberately dropped.
   logic                    unused_wd;
   assign unused_wd = ^writedata;

   assign wr      = chipselect & ~write_n;
   assign wdec    = decode_write(address, wr);
   assign wd_data = writedata[DATA_WIDTH-1:0];

   // ---------------- register file ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= RESET_DATA;
      end else if (wdec.data) begin
         data <= wd_data;
      end else if (wdec.set) begin
         data <= data | wd_data;
      end else if (wdec.clr) begin
         data <= data & ~wd_data;
      end else if (wdec.tgl) begin
         data <= data ^ wd_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask   <= '0;
         period <= PERIOD_WIDTH'(RESET_PERIOD);
         en     <= 1'b0;
      end else begin
         if (wdec.mask)   mask   <= wd_data;
         if (wdec.period) period <= writedata[PERIOD_WIDTH-1:0];
         if (wdec.ctrl)   en     <= writedata[CTRL_EN];
      end
   end

   // The timer must clear phase on the same edge that a CTRL write drops en,
   // so it sees en already low during that write rather than one cycle later.
   assign timer_en = en & ~(wdec.ctrl & ~writedata[CTRL_EN]);

   led_blink_timer #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period),
      .en      (timer_en),
      .restart (wdec.period),
      .phase   (phase)
   );

   // ---------------- output flop ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= RESET_DATA;
      end else begin
         out_port <= data ^ (mask & {DATA_WIDTH{phase}});
      end
   end

   // ---------------- read mux ----------------
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:   readdata = 32'(data);
         ADDR_MASK:   readdata = 32'(mask);
         ADDR_PERIOD: readdata = 32'(period);
         ADDR_CTRL: begin
            readdata[CTRL_EN]    = en;
            readdata[CTRL_PHASE] = phase;
         end
         default:     readdata = '0;   // write-only and reserved addresses
      endcase
   end

endmodule
